// File: rtl/result_packer_if.sv
// Result-word stream in, packed 64-bit beat stream out, grouped as one bundle.
// The slave modport is the packer's view; master is the producer/consumer view.
interface result_packer_if;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_ready;
  logic        dst_valid;
  logic [63:0] dst_data;
  logic        dst_last;
  logic        dst_ready;

  modport master (
    output res_valid, res_data, dst_ready,
    input  res_ready, dst_valid, dst_data, dst_last
  );

  modport slave (
    input  res_valid, res_data, dst_ready,
    output res_ready, dst_valid, dst_data, dst_last
  );
endinterface

// File: rtl/result_packer.sv
// Packs a frame of 32-bit result words into 64-bit beats through a FWFT FIFO.
// One-cycle push-to-valid latency; a full FIFO stalls the producer via res_ready.

module result_packer_fifo #(
  parameter int W     = 65,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  // Head reads as zero when empty so the output bus is clean after reset.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module result_packer #(
  parameter int DEPTH = 16,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  output logic             busy,
  result_packer_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic        last;
    logic [63:0] data;
  } beat_t;

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state;
  state_t           next_state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] word_cnt;
  logic [31:0]      holder;
  logic             accept;
  logic             last_word;
  logic             launch;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  beat_t            push_beat;
  beat_t            head_beat;

  assign accept    = bus.res_valid & bus.res_ready;
  assign last_word = (word_cnt == len_q - LEN_ONE);
  assign launch    = (state == IDLE) & start & (frame_len != '0);
  // A beat closes on every odd word, or early on the final word of an odd frame.
  assign push      = accept & (word_cnt[0] | last_word);
  assign pop       = bus.dst_valid & bus.dst_ready;

  always_comb begin
    push_beat.last = last_word;
    push_beat.data = word_cnt[0] ? {bus.res_data, holder} : {32'h0, bus.res_data};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (launch) next_state = RUN;
      RUN:     if (accept && last_word) next_state = DRAIN;
      DRAIN:   if (pop && bus.dst_last) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.res_ready = (state == RUN) & ~full;
    busy          = (state != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q    <= '0;
      word_cnt <= '0;
      holder   <= '0;
    end else if (launch) begin
      len_q    <= frame_len;
      word_cnt <= '0;
      holder   <= '0;
    end else if (accept) begin
      word_cnt <= word_cnt + LEN_ONE;
      if (!word_cnt[0]) holder <= bus.res_data;
    end
  end

  result_packer_fifo #(
    .W     ($bits(beat_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_beat),
    .pop      (pop),
    .head     (head_beat),
    .empty    (empty),
    .full     (full)
  );

  assign bus.dst_valid = ~empty;
  assign bus.dst_data  = head_beat.data;
  assign bus.dst_last  = head_beat.last;
endmodule
